// File: rtl/signed_add_pkg.sv
// signed_add_pkg: shared state encoding and default sizes for the signed add scheduler
package signed_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NUM_REQ = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req bit at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);
  // Scan offsets from far to near so the nearest requester to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/signed_add_scheduler.sv
// signed_add_scheduler: round-robin time-sharing of one signed adder with a tagged result port
module signed_add_scheduler
  import signed_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH:0]           resp_sum,
  output logic                     resp_ovf,
  output logic                     busy
);
  state_t state;
  logic [ID_W-1:0] rr_ptr, id_q, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0] sum;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  assign req_ready = (state == IDLE) ? win_gnt : '0;
  assign busy = state != IDLE;
  // One extra bit of headroom makes the sum exact; overflow is the top two bits disagreeing.
  assign sum = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_sum <= '0;
      resp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          a_q <= req_a[win_idx*WIDTH +: WIDTH];
          b_q <= req_b[win_idx*WIDTH +: WIDTH];
          id_q <= win_idx;
          rr_ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          resp_sum <= sum;
          resp_ovf <= sum[WIDTH] ^ sum[WIDTH-1];
          resp_id <= id_q;
          resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
